ifm_pingpong_buffer_u3: RTL and testbench



---
 rtl/ifm_buf_pkg.sv | 15 +
 rtl/ifm_bank_ram.sv | 32 +++
 rtl/ifm_pingpong_buffer_u3.sv | 111 +++++++++++
 tb/tb_ifm_pingpong_buffer_u3.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifm_buf_pkg.sv
// ifm_buf_pkg: shared sizing, bank index and reader-state types for the IFM ping-pong buffer
package ifm_buf_pkg;
  localparam int DATA_WIDTH_D = 32;
  localparam int IFM_SIZE_D = 5;
  localparam int IFM_DEPTH_D = 16;
  localparam int NUMBER_OF_UNITS = 3;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
  localparam int GROUPS_D = ceil_div(IFM_DEPTH_D, NUMBER_OF_UNITS);
  localparam int ADDRESS_SIZE_D = $clog2(IFM_SIZE_D * IFM_SIZE_D);
  localparam int SEL_WIDTH_D = $clog2(GROUPS_D);
  typedef logic bank_t;
  typedef enum logic {RD_IDLE, RD_BUSY} rd_state_t;
endpackage

// File: rtl/ifm_bank_ram.sv
// ifm_bank_ram: one-write two-read synchronous RAM with registered, enable-held outputs
module ifm_bank_ram #(
  parameter int DW = 32,
  parameter int DEPTH = 300,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          en_a,
  input  logic          ok_a,
  input  logic [AW-1:0] addr_a,
  input  logic          en_b,
  input  logic          ok_b,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] q_a,
  output logic [DW-1:0] q_b
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      if (en_a) q_a <= ok_a ? mem[addr_a] : '0;
      if (en_b) q_b <= ok_b ? mem[addr_b] : '0;
    end
endmodule

// File: rtl/ifm_pingpong_buffer_u3.sv
// ifm_pingpong_buffer_u3: double-buffered IFM store between 3-lane max-pool and next conv layer
module ifm_pingpong_buffer_u3 import ifm_buf_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int IFM_SIZE = IFM_SIZE_D,
  parameter int IFM_DEPTH = IFM_DEPTH_D,
  localparam int GROUPS = ceil_div(IFM_DEPTH, NUMBER_OF_UNITS),
  localparam int ADDRESS_SIZE = $clog2(IFM_SIZE * IFM_SIZE),
  localparam int SEL_WIDTH = $clog2(GROUPS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ifm_enable_write,
  input  logic [ADDRESS_SIZE-1:0] ifm_address_write,
  input  logic [SEL_WIDTH-1:0]    ifm_sel_write,
  input  logic [DATA_WIDTH-1:0]   data_in_1,
  input  logic [DATA_WIDTH-1:0]   data_in_2,
  input  logic [DATA_WIDTH-1:0]   data_in_3,
  input  logic                    start_from_previous,
  output logic                    ready_to_previous,
  output logic                    end_to_previous,
  input  logic                    ifm_enable_read_A,
  input  logic                    ifm_enable_read_B,
  input  logic [ADDRESS_SIZE-1:0] ifm_address_read_A,
  input  logic [ADDRESS_SIZE-1:0] ifm_address_read_B,
  input  logic [SEL_WIDTH-1:0]    ifm_sel_read,
  output logic [DATA_WIDTH-1:0]   data_out_A_unit1,
  output logic [DATA_WIDTH-1:0]   data_out_A_unit2,
  output logic [DATA_WIDTH-1:0]   data_out_A_unit3,
  output logic [DATA_WIDTH-1:0]   data_out_B_unit1,
  output logic [DATA_WIDTH-1:0]   data_out_B_unit2,
  output logic [DATA_WIDTH-1:0]   data_out_B_unit3,
  output logic                    start_to_next,
  input  logic                    end_from_next
);
  localparam int PIX = IFM_SIZE * IFM_SIZE;
  localparam int BANK_WORDS = GROUPS * PIX;
  localparam int DEPTH = 2 * BANK_WORDS;
  localparam int RAW = $clog2(DEPTH);

  function automatic logic in_range(input logic [SEL_WIDTH-1:0] s, input logic [ADDRESS_SIZE-1:0] a);
    return (int'(s) < GROUPS) && (int'(a) < PIX);
  endfunction

  function automatic logic [RAW-1:0] map(input bank_t b, input logic [SEL_WIDTH-1:0] s,
                                         input logic [ADDRESS_SIZE-1:0] a);
    return RAW'(int'(b) * BANK_WORDS + int'(s) * PIX + int'(a));
  endfunction

  logic [1:0] full;
  bank_t wr_bank, rd_bank;
  rd_state_t state;
  logic we, ok_a, ok_b;
  logic [RAW-1:0] waddr, raddr_a, raddr_b;
  logic [DATA_WIDTH-1:0] din [3];
  logic [DATA_WIDTH-1:0] qa [3];
  logic [DATA_WIDTH-1:0] qb [3];

  assign ready_to_previous = !full[wr_bank];
  assign we = ifm_enable_write && !full[wr_bank] && in_range(ifm_sel_write, ifm_address_write);
  assign ok_a = in_range(ifm_sel_read, ifm_address_read_A);
  assign ok_b = in_range(ifm_sel_read, ifm_address_read_B);
  assign waddr = map(wr_bank, ifm_sel_write, ifm_address_write);
  assign raddr_a = map(rd_bank, ifm_sel_read, ifm_address_read_A);
  assign raddr_b = map(rd_bank, ifm_sel_read, ifm_address_read_B);
  assign din[0] = data_in_1;
  assign din[1] = data_in_2;
  assign din[2] = data_in_3;
  assign data_out_A_unit1 = qa[0];
  assign data_out_A_unit2 = qa[1];
  assign data_out_A_unit3 = qa[2];
  assign data_out_B_unit1 = qb[0];
  assign data_out_B_unit2 = qb[1];
  assign data_out_B_unit3 = qb[2];

  for (genvar i = 0; i < 3; i++) begin : g_lane
    ifm_bank_ram #(.DW(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk(clk), .rst_n(reset), .we(we), .waddr(waddr), .wdata(din[i]),
      .en_a(ifm_enable_read_A), .ok_a(ok_a), .addr_a(raddr_a),
      .en_b(ifm_enable_read_B), .ok_b(ok_b), .addr_b(raddr_b),
      .q_a(qa[i]), .q_b(qb[i])
    );
  end

  // Set and clear cannot hit the same bank: a full write bank refuses the set.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      state <= RD_IDLE;
      start_to_next <= 1'b0;
      end_to_previous <= 1'b0;
    end else begin
      start_to_next <= 1'b0;
      end_to_previous <= 1'b0;
      if (start_from_previous && !full[wr_bank]) begin
        full[wr_bank] <= 1'b1;
        wr_bank <= !wr_bank;
      end
      if (state == RD_IDLE && full[rd_bank]) begin
        start_to_next <= 1'b1;
        state <= RD_BUSY;
      end
      if (state == RD_BUSY && end_from_next) begin
        full[rd_bank] <= 1'b0;
        rd_bank <= !rd_bank;
        state <= RD_IDLE;
        end_to_previous <= 1'b1;
      end
    end
endmodule

// File: tb/tb_ifm_pingpong_buffer_u3.sv
// tb_ifm_pingpong_buffer_u3: table-driven reads with a scoreboard plus handshake corner sequences
module tb_ifm_pingpong_buffer_u3;
  logic clk = 1'b0, reset = 1'b0;
  logic ifm_enable_write = 1'b0, start_from_previous = 1'b0, end_from_next = 1'b0;
  logic [4:0] ifm_address_write = '0, ifm_address_read_A = '0, ifm_address_read_B = '0;
  logic [2:0] ifm_sel_write = '0, ifm_sel_read = '0;
  logic [31:0] data_in_1 = '0, data_in_2 = '0, data_in_3 = '0;
  logic ifm_enable_read_A = 1'b0, ifm_enable_read_B = 1'b0;
  logic ready_to_previous, end_to_previous, start_to_next;
  logic [31:0] data_out_A_unit1, data_out_A_unit2, data_out_A_unit3;
  logic [31:0] data_out_B_unit1, data_out_B_unit2, data_out_B_unit3;

  ifm_pingpong_buffer_u3 dut (
    .clk(clk), .reset(reset), .ifm_enable_write(ifm_enable_write),
    .ifm_address_write(ifm_address_write), .ifm_sel_write(ifm_sel_write),
    .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
    .start_from_previous(start_from_previous), .ready_to_previous(ready_to_previous),
    .end_to_previous(end_to_previous), .ifm_enable_read_A(ifm_enable_read_A),
    .ifm_enable_read_B(ifm_enable_read_B), .ifm_address_read_A(ifm_address_read_A),
    .ifm_address_read_B(ifm_address_read_B), .ifm_sel_read(ifm_sel_read),
    .data_out_A_unit1(data_out_A_unit1), .data_out_A_unit2(data_out_A_unit2),
    .data_out_A_unit3(data_out_A_unit3), .data_out_B_unit1(data_out_B_unit1),
    .data_out_B_unit2(data_out_B_unit2), .data_out_B_unit3(data_out_B_unit3),
    .start_to_next(start_to_next), .end_from_next(end_from_next)
  );

  always #5 clk = ~clk;

  typedef logic [2:0][31:0] lanes_t;
  typedef struct { lanes_t a; lanes_t b; } exp_t;
  typedef struct { bit ea; bit eb; int aa; int ab; int s; lanes_t xa; lanes_t xb; } vec_t;

  int vectors = 0, miscompares = 0;
  exp_t sbq[$];
  lanes_t ha = '0, hb = '0;
  int bank_gen[2] = '{0, 0};
  bit mrd = 1'b0;
  vec_t tbl[8];
  lanes_t oa, ob;

  assign oa = {data_out_A_unit3, data_out_A_unit2, data_out_A_unit1};
  assign ob = {data_out_B_unit3, data_out_B_unit2, data_out_B_unit1};

  function automatic logic [31:0] val(int gen, int u, int s, int a);
    return 32'(gen * 50000 + 1000 * u + 100 * s + a);
  endfunction

  function automatic lanes_t lanes(int gen, int s, int a);
    lanes_t r;
    for (int u = 0; u < 3; u++) r[u] = val(gen, u + 1, s, a);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic compare_pop(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sbq.pop_front();
    for (int u = 0; u < 3; u++) begin
      check($sformatf("%s_A_unit%0d", name, u + 1), oa[u], e.a[u]);
      check($sformatf("%s_B_unit%0d", name, u + 1), ob[u], e.b[u]);
    end
  endtask

  task automatic drive_read(input bit ea, input int aa, input bit eb, input int ab, input int s);
    ifm_enable_read_A = ea;
    ifm_enable_read_B = eb;
    ifm_address_read_A = 5'(aa);
    ifm_address_read_B = 5'(ab);
    ifm_sel_read = 3'(s);
    tick();
    ifm_enable_read_A = 1'b0;
    ifm_enable_read_B = 1'b0;
  endtask

  task automatic rd(input string name, input bit ea, input int aa, input bit eb, input int ab, input int s);
    if (ea) ha = (s < 6 && aa < 25) ? lanes(bank_gen[mrd], s, aa) : '0;
    if (eb) hb = (s < 6 && ab < 25) ? lanes(bank_gen[mrd], s, ab) : '0;
    sbq.push_back('{a: ha, b: hb});
    drive_read(ea, aa, eb, ab, s);
    compare_pop(name);
  endtask

  task automatic wr(input int s, input int a, input int gen);
    ifm_enable_write = 1'b1;
    ifm_sel_write = 3'(s);
    ifm_address_write = 5'(a);
    data_in_1 = val(gen, 1, s, a);
    data_in_2 = val(gen, 2, s, a);
    data_in_3 = val(gen, 3, s, a);
    tick();
    ifm_enable_write = 1'b0;
  endtask

  task automatic fill(input int gen);
    for (int s = 0; s < 6; s++)
      for (int a = 0; a < 25; a++) wr(s, a, gen);
  endtask

  initial begin
    tbl[0] = '{1, 1, 7, 24, 2, lanes(0, 2, 7), lanes(0, 2, 24)};
    tbl[1] = '{1, 1, 0, 24, 5, lanes(0, 5, 0), lanes(0, 5, 24)};
    tbl[2] = '{1, 1, 25, 3, 0, '0, lanes(0, 0, 3)};
    tbl[3] = '{1, 1, 1, 1, 6, '0, '0};
    tbl[4] = '{0, 1, 9, 12, 4, '0, lanes(0, 4, 12)};
    tbl[5] = '{1, 0, 13, 2, 3, lanes(0, 3, 13), lanes(0, 4, 12)};
    tbl[6] = '{1, 1, 31, 0, 1, '0, lanes(0, 1, 0)};
    tbl[7] = '{1, 1, 24, 24, 5, lanes(0, 5, 24), lanes(0, 5, 24)};

    #12;
    check("rst_ready", 32'(ready_to_previous), 1);
    check("rst_start_to_next", 32'(start_to_next), 0);
    check("rst_end_to_previous", 32'(end_to_previous), 0);
    check("rst_outA1", data_out_A_unit1, 0);
    check("rst_outB3", data_out_B_unit3, 0);
    @(negedge clk) reset = 1'b1;
    tick();

    wr(0, 0, 0);
    start_from_previous = 1'b1;
    rd("midfill_read", 1, 0, 0, 0, 0);
    start_from_previous = 1'b0;
    reset = 1'b0;
    #2;
    ha = '0;
    hb = '0;
    check("midrst_ready", 32'(ready_to_previous), 1);
    check("midrst_start_to_next", 32'(start_to_next), 0);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("midrst_outA%0d", u + 1), oa[u], 0);
      check($sformatf("midrst_outB%0d", u + 1), ob[u], 0);
    end
    tick();
    @(negedge clk) reset = 1'b1;
    tick();
    tick();
    check("midrst_no_launch", 32'(start_to_next), 0);

    fill(0);
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
    check("launch_k", 32'(start_to_next), 0);
    check("launch_ready", 32'(ready_to_previous), 1);
    tick();
    check("launch_k1", 32'(start_to_next), 1);
    tick();
    check("launch_k2", 32'(start_to_next), 0);

    for (int i = 0; i < 8; i++) begin
      sbq.push_back('{a: tbl[i].xa, b: tbl[i].xb});
      drive_read(tbl[i].ea, tbl[i].aa, tbl[i].eb, tbl[i].ab, tbl[i].s);
      compare_pop($sformatf("tbl%0d", i));
      ha = tbl[i].xa;
      hb = tbl[i].xb;
    end

    fill(1);
    bank_gen[1] = 1;
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
    check("both_full_ready", 32'(ready_to_previous), 0);
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
    check("third_start_ready", 32'(ready_to_previous), 0);
    check("third_start_pulse", 32'(start_to_next), 0);
    wr(2, 7, 9);
    rd("dropped_write", 1, 7, 0, 0, 2);

    end_from_next = 1'b1;
    tick();
    end_from_next = 1'b0;
    mrd = 1'b1;
    check("end_pulse", 32'(end_to_previous), 1);
    check("end_ready", 32'(ready_to_previous), 1);
    tick();
    check("end_pulse_off", 32'(end_to_previous), 0);
    check("bank1_launch", 32'(start_to_next), 1);
    rd("bank1_read", 1, 7, 1, 24, 2);

    fill(2);
    bank_gen[0] = 2;
    start_from_previous = 1'b1;
    end_from_next = 1'b1;
    tick();
    start_from_previous = 1'b0;
    end_from_next = 1'b0;
    mrd = 1'b0;
    check("simul_end_pulse", 32'(end_to_previous), 1);
    check("simul_ready", 32'(ready_to_previous), 1);
    check("simul_no_launch_yet", 32'(start_to_next), 0);
    tick();
    check("simul_launch", 32'(start_to_next), 1);
    rd("simul_read", 1, 0, 1, 24, 5);

    end_from_next = 1'b1;
    tick();
    end_from_next = 1'b0;
    mrd = 1'b1;
    check("free_end_pulse", 32'(end_to_previous), 1);
    tick();
    check("idle_no_launch", 32'(start_to_next), 0);
    end_from_next = 1'b1;
    tick();
    end_from_next = 1'b0;
    check("idle_end_ignored", 32'(end_to_previous), 0);
    check("idle_ready", 32'(ready_to_previous), 1);
    wr(0, 25, 7);
    wr(6, 0, 7);
    wr(7, 31, 7);
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
    tick();
    check("relaunch_bank1", 32'(start_to_next), 1);
    rd("oor_no_corrupt", 1, 0, 1, 25, 1);
    rd("oor_sel0", 1, 0, 1, 24, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
